// File: rtl/opseq_pkg.sv
// -----------------------------------------------------------------------------
// opseq_pkg
// Shared definitions for the operand sequencer front end.
//   state_t : FSM state encoding, which is also the LED code driven on `estado`
//   W       : default operand width
//   SAT_MAX : saturation value for an unsigned sum that exceeds the operand range
// -----------------------------------------------------------------------------
package opseq_pkg;

    localparam int W = 8;

    localparam logic [8:0] SAT_MAX = 9'd255;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_CALC   = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns a raw, bouncing, asynchronous pushbutton into a single-cycle press
// pulse: 2-FF synchroniser -> optional debouncer -> rising-edge detector.
//
// Optional feature macro: OPSEQ_DEBOUNCE_EN
//   defined   : a level must be stable for DEBOUNCE_CYCLES cycles before it is
//               accepted.
//   undefined : the synchroniser output feeds the edge detector directly.
//
// Ports
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   btn   in  raw pushbutton, active-high
//   press out one-cycle pulse on each accepted rising edge of the button
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic sync0;
    logic sync1;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

`ifdef OPSEQ_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to the accepted level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level = sync1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // A level that was already high when reset released still yields one
    // press, because level_q restarts from 0.
    assign press = level & ~level_q;

endmodule

// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
// Front-end control stage for the signed-result seven-segment display.
// Steps through operand A entry, operand B entry, compute and show, and
// presents a registered W+1-bit two's-complement value to the display stage.
// In the load states the registered switch value is previewed on `resultado`.
//
// Optional feature macro: OPSEQ_DEBOUNCE_EN (selects the button debouncer).
//
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   sw        in  W-bit unsigned operand from the switches
//   op        in  0 = A+B, 1 = A-B; taken when B is accepted
//   btn       in  raw pushbutton, active-high
//   resultado out W+1-bit two's-complement result / preview
//   valid     out high while a computed result is shown
//   ovf       out saturation flag for the shown result
//   estado    out FSM state for the LEDs
// -----------------------------------------------------------------------------
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int W               = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         op,
    input  logic         btn,
    output logic [W:0]   resultado,
    output logic         valid,
    output logic         ovf,
    output logic [1:0]   estado
);

    import opseq_pkg::*;

    localparam logic [W:0] SAT = {1'b0, {W{1'b1}}};

    state_t       state;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_q;
    logic         press;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .press(press)
    );

    // Returns {ovf, result}. Operands are zero-extended to W+1 bits; a
    // difference always fits, while an unsigned sum that reaches the top bit
    // has exceeded the W-bit range and is clamped.
    function automatic logic [W+1:0] calc_result(input logic [W-1:0] x,
                                                 input logic [W-1:0] y,
                                                 input logic         sub);
        logic signed [W:0] ex;
        logic signed [W:0] ey;
        logic signed [W:0] r;
        ex = signed'({1'b0, x});
        ey = signed'({1'b0, y});
        r  = sub ? (ex - ey) : (ex + ey);
        if (!sub && r[W]) begin
            return {1'b1, SAT};
        end
        return {1'b0, r};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD_A;
            a         <= '0;
            b         <= '0;
            op_q      <= 1'b0;
            resultado <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: begin
                    resultado <= {1'b0, sw};
                    valid     <= 1'b0;
                    if (press) begin
                        a     <= sw;
                        state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    resultado <= {1'b0, sw};
                    valid     <= 1'b0;
                    if (press) begin
                        b     <= sw;
                        op_q  <= op;
                        state <= ST_CALC;
                    end
                end
                // Single cycle; a press arriving here is dropped.
                ST_CALC: begin
                    {ovf, resultado} <= calc_result(a, b, op_q);
                    valid            <= 1'b1;
                    state            <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (press) begin
                        a     <= '0;
                        b     <= '0;
                        ovf   <= 1'b0;
                        valid <= 1'b0;
                        state <= ST_LOAD_A;
                    end
                end
                default: state <= ST_LOAD_A;
            endcase
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

    localparam int DEB = 4;
`ifdef OPSEQ_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [8:0] res;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic       op;
    logic       btn;
    logic [8:0] resultado;
    logic       valid;
    logic       ovf;
    logic [1:0] estado;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    operand_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .op       (op),
        .btn      (btn),
        .resultado(resultado),
        .valid    (valid),
        .ovf      (ovf),
        .estado   (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input bit sub);
        exp_t e;
        int   r;
        r = sub ? (x - y) : (x + y);
        if (!sub && r > 255) begin
            e.res = 9'h0FF;
            e.ovf = 1'b1;
        end else begin
            e.res = r[8:0];
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Raise btn at a falling edge and count rising edges until estado moves.
    task automatic press_btn(input logic [1:0] exp_state, input string tag);
        logic [1:0] st0;
        int         n;
        st0 = estado;
        n   = 0;
        @(negedge clk);
        btn = 1'b1;
        while (estado == st0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_state"}, estado, exp_state);
    endtask

    task automatic release_btn();
        @(negedge clk);
        btn = 1'b0;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic do_op(input int x, input int y, input bit sub, input string tag);
        exp_t e;
        @(negedge clk);
        sw = x[7:0];
        press_btn(2'd1, {tag, "_a"});
        release_btn();
        chk({tag, "_preview_b"}, resultado, {1'b0, x[7:0]});
        @(negedge clk);
        sw = y[7:0];
        op = sub;
        sb.push_back(model(x, y, sub));
        press_btn(2'd2, {tag, "_b"});
        @(posedge clk);
        #1;
        chk({tag, "_show_state"}, estado, 2'd3);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, resultado, e.res);
            chk({tag, "_ovf"}, ovf, e.ovf);
            chk({tag, "_valid"}, valid, 1'b1);
        end
        @(negedge clk);
        sw = ~sw;
        op = ~op;
        release_btn();
        chk({tag, "_hold_state"}, estado, 2'd3);
        chk({tag, "_hold_res"}, resultado, e.res);
    endtask

    task automatic clear_show(input string tag);
        press_btn(2'd0, tag);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_ovf"}, ovf, 1'b0);
        release_btn();
        sw = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_preview"}, resultado, 9'h03C);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn         = 1'b0;
        sw          = 8'hA5;
        op          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_estado", estado, 2'd0);
        chk("rst_res", resultado, 9'h000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        @(negedge clk);
        sw = 8'h5A;
        @(negedge clk);
        chk("preview_a", resultado, 9'h05A);
        chk("preview_a_valid", valid, 1'b0);

        do_op(100, 27, 1'b0, "add_127");
        clear_show("clr1");
        do_op(2, 4, 1'b1, "sub_m2");
        clear_show("clr2");
        do_op(200, 100, 1'b0, "add_sat");
        clear_show("clr3");
        do_op(255, 0, 1'b0, "add_255");
        clear_show("clr4");
        do_op(128, 128, 1'b0, "add_256");
        clear_show("clr5");
        do_op(0, 255, 1'b1, "sub_m255");
        clear_show("clr6");

`ifdef OPSEQ_DEBOUNCE_EN
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            btn = 1'b1;
            repeat (k) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_advance", estado, 2'd0);
        press_btn(2'd1, "bounce_stable");
        repeat (10 - LAT) @(negedge clk);
        chk("bounce_single", estado, 2'd1);
        release_btn();
        chk("bounce_after_release", estado, 2'd1);
`else
        press_btn(2'd1, "held_a");
        repeat (10) @(negedge clk);
        chk("held_single", estado, 2'd1);
        release_btn();
        chk("held_after_release", estado, 2'd1);
`endif

        @(negedge clk);
        sw = 8'd50;
        op = 1'b0;
        press_btn(2'd2, "rst_mid_b");
        @(posedge clk);
        #1;
        chk("rst_mid_show", estado, 2'd3);
        release_btn();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_estado", estado, 2'd0);
        chk("rst_mid_res", resultado, 9'h000);
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        sb.delete();
        do_op(10, 3, 1'b1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
